// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// nco_pkg : shared types for the multi-channel NCO phase engine
// Rev 1.0
// ============================================================================
package nco_pkg;

  localparam int unsigned NCO_PW = 32;

  typedef enum logic [1:0] {
    CFG_STEP   = 2'd0,
    CFG_OFFSET = 2'd1,
    CFG_DELTA  = 2'd2,
    CFG_LIMIT  = 2'd3
  } cfg_addr_e;

  // Default-width view of one channel's register bank; users with a
  // different phase width declare the same layout at their own width.
  typedef struct packed {
    logic [NCO_PW-1:0] step;
    logic [NCO_PW-1:0] off;
    logic [NCO_PW-1:0] delta;
    logic [NCO_PW-1:0] limit;
  } ch_regs_t;

endpackage
`default_nettype wire

// File: rtl/nco_channel.sv
`default_nettype none
// ============================================================================
// nco_channel : one double-buffered phase accumulator with linear chirp
// Rev 1.0
// ============================================================================
module nco_channel
  import nco_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          en_i,
  input  logic          wr_i,
  input  cfg_addr_e     addr_i,
  input  logic [PW-1:0] data_i,
  input  logic          sync_i,
  output logic [PW-1:0] phase_o,
  output logic          wrap_o,
  output logic          chirp_wrap_o
);

  typedef struct packed {
    logic [PW-1:0] step;
    logic [PW-1:0] off;
    logic [PW-1:0] delta;
    logic [PW-1:0] limit;
  } regs_t;

  regs_t         shadow_q, shadow_d;
  regs_t         active_q, active_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          wrap_q, wrap_d;
  logic          cwrap_q, cwrap_d;

  logic [PW:0]   acc_sum;
  logic [PW:0]   chirp_nxt;
  logic          chirp_on;
  logic          chirp_reload;
  logic          advance;

  always_comb begin
    acc_sum      = {1'b0, acc_q} + {1'b0, active_q.step};
    chirp_nxt    = {1'b0, active_q.step} + {1'b0, active_q.delta};
    chirp_on     = |active_q.delta;
    chirp_reload = chirp_nxt[PW] || (chirp_nxt > {1'b0, active_q.limit});
    advance      = en_i & ~sync_i;

    shadow_d = shadow_q;
    if (wr_i) begin
      case (addr_i)
        CFG_STEP:   shadow_d.step  = data_i;
        CFG_OFFSET: shadow_d.off   = data_i;
        CFG_DELTA:  shadow_d.delta = data_i;
        CFG_LIMIT:  shadow_d.limit = data_i;
      endcase
    end

    active_d = active_q;
    acc_d    = acc_q;
    if (sync_i) begin
      active_d = shadow_q;
      acc_d    = '0;
    end else if (en_i) begin
      acc_d = acc_sum[PW-1:0];
      // Sweep restarts from the programmed start step, not from zero
      if (chirp_on) begin
        active_d.step = chirp_reload ? shadow_q.step : chirp_nxt[PW-1:0];
      end
    end

    phase_d = en_i ? (acc_q + active_q.off) : phase_q;
    wrap_d  = advance & acc_sum[PW];
    cwrap_d = advance & chirp_on & chirp_reload;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      shadow_q <= '0;
      active_q <= '0;
      acc_q    <= '0;
      phase_q  <= '0;
      wrap_q   <= 1'b0;
      cwrap_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      wrap_q   <= wrap_d;
      cwrap_q  <= cwrap_d;
    end
  end

  assign phase_o      = phase_q;
  assign wrap_o       = wrap_q;
  assign chirp_wrap_o = cwrap_q;

endmodule
`default_nettype wire

// File: rtl/nco_phase_engine.sv
`default_nettype none
// ============================================================================
// nco_phase_engine : NUM_CH phase accumulators with shared config/sync port
// Rev 1.0
// ============================================================================
module nco_phase_engine
  import nco_pkg::*;
#(
  parameter int PHASE_WORD_WIDTH = 32,
  parameter int NUM_CH           = 4,
  parameter int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic [CH_W-1:0]              i_cfg_ch,
  input  logic [1:0]                   i_cfg_addr,
  input  logic [PHASE_WORD_WIDTH-1:0]  i_cfg_data,
  input  logic                         i_sync,
  input  logic [NUM_CH-1:0]            i_sync_mask,
  output logic [NUM_CH*PHASE_WORD_WIDTH-1:0] o_phase,
  output logic                         o_phase_valid,
  output logic [NUM_CH-1:0]            o_wrap,
  output logic [NUM_CH-1:0]            o_chirp_wrap
);

  localparam int PW = PHASE_WORD_WIDTH;

  logic      ready_q;
  logic      valid_q;
  logic      wr_accept;
  cfg_addr_e cfg_addr;

  // Blocking writes during sync guarantees sync copies pre-write shadows
  assign o_cfg_ready = ready_q & ~i_sync;
  assign wr_accept   = i_cfg_valid & o_cfg_ready;
  assign cfg_addr    = cfg_addr_e'(i_cfg_addr);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      valid_q <= i_en;
    end
  end

  assign o_phase_valid = valid_q;

  // Writes addressed past the last channel match no instance and vanish
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_c;
    assign wr_c = wr_accept && (i_cfg_ch == CH_W'(c));

    nco_channel #(
      .PW (PW)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .en_i         (i_en),
      .wr_i         (wr_c),
      .addr_i       (cfg_addr),
      .data_i       (i_cfg_data),
      .sync_i       (i_sync & i_sync_mask[c]),
      .phase_o      (o_phase[c*PW +: PW]),
      .wrap_o       (o_wrap[c]),
      .chirp_wrap_o (o_chirp_wrap[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_phase_engine.sv
`default_nettype none
// ============================================================================
// tb_nco_phase_engine : directed stimulus against a cycle-level reference model
// Rev 1.0
// ============================================================================
module tb_nco_phase_engine;

  logic         clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_en = 1'b0;
  logic         i_cfg_valid = 1'b0;
  logic         o_cfg_ready;
  logic [1:0]   i_cfg_ch = '0;
  logic [1:0]   i_cfg_addr = '0;
  logic [31:0]  i_cfg_data = '0;
  logic         i_sync = 1'b0;
  logic [3:0]   i_sync_mask = '0;
  logic [127:0] o_phase;
  logic         o_phase_valid;
  logic [3:0]   o_wrap;
  logic [3:0]   o_chirp_wrap;

  int checks = 0;
  int errors = 0;

  nco_phase_engine #(.PHASE_WORD_WIDTH(32), .NUM_CH(4)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_cfg_valid   (i_cfg_valid),
    .o_cfg_ready   (o_cfg_ready),
    .i_cfg_ch      (i_cfg_ch),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_data    (i_cfg_data),
    .i_sync        (i_sync),
    .i_sync_mask   (i_sync_mask),
    .o_phase       (o_phase),
    .o_phase_valid (o_phase_valid),
    .o_wrap        (o_wrap),
    .o_chirp_wrap  (o_chirp_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Reference model: register banks as [channel][field] arrays, field 0..3 =
  // step, offset, delta, limit; arithmetic done in 64 bits.
  logic [31:0] m_sh  [4][4];
  logic [31:0] m_act [4][4];
  logic [31:0] m_acc [4];
  logic [31:0] m_phase [4];
  logic [3:0]  m_wrap = '0;
  logic [3:0]  m_cw = '0;
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        started = 1'b0;

  always @(posedge clk) begin
    logic [63:0] sum;
    logic [63:0] nxt;
    logic        take;
    started = 1'b1;
    if (!i_rst) begin
      for (int c = 0; c < 4; c++) begin
        for (int a = 0; a < 4; a++) begin
          m_sh[c][a]  = 32'd0;
          m_act[c][a] = 32'd0;
        end
        m_acc[c]   = 32'd0;
        m_phase[c] = 32'd0;
      end
      m_wrap  = '0;
      m_cw    = '0;
      m_valid = 1'b0;
      m_ready = 1'b0;
    end else begin
      take    = i_cfg_valid && m_ready && !i_sync;
      m_valid = i_en;
      for (int c = 0; c < 4; c++) begin
        m_wrap[c] = 1'b0;
        m_cw[c]   = 1'b0;
        if (i_en) m_phase[c] = m_acc[c] + m_act[c][1];
        if (i_sync && i_sync_mask[c]) begin
          for (int a = 0; a < 4; a++) m_act[c][a] = m_sh[c][a];
          m_acc[c] = 32'd0;
        end else if (i_en) begin
          sum       = 64'(m_acc[c]) + 64'(m_act[c][0]);
          m_wrap[c] = (sum >= 64'h1_0000_0000);
          m_acc[c]  = sum[31:0];
          if (m_act[c][2] != 32'd0) begin
            nxt = 64'(m_act[c][0]) + 64'(m_act[c][2]);
            if (nxt > 64'(m_act[c][3])) begin
              m_act[c][0] = m_sh[c][0];
              m_cw[c]     = 1'b1;
            end else begin
              m_act[c][0] = nxt[31:0];
            end
          end
        end
      end
      if (take) m_sh[i_cfg_ch][i_cfg_addr] = i_cfg_data;
      m_ready = 1'b1;
    end
  end

  // Compare every cycle, mid-period, against the model
  always @(negedge clk) begin
    if (started) begin
      chk("valid", o_phase_valid, m_valid);
      chk("wrap", o_wrap, m_wrap);
      chk("chirp_wrap", o_chirp_wrap, m_cw);
      chk("cfg_ready", o_cfg_ready, m_ready & ~i_sync);
      for (int c = 0; c < 4; c++)
        chk($sformatf("phase_ch%0d", c), o_phase[c*32 +: 32], m_phase[c]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] addr, input logic [31:0] data);
    i_cfg_valid = 1'b1;
    i_cfg_ch    = ch;
    i_cfg_addr  = addr;
    i_cfg_data  = data;
    tick;
    i_cfg_valid = 1'b0;
  endtask

  task automatic sync(input logic [3:0] mask);
    i_sync      = 1'b1;
    i_sync_mask = mask;
    tick;
    i_sync      = 1'b0;
    i_sync_mask = '0;
  endtask

  logic [31:0] t1 [5] = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
  logic [31:0] t2 [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
  logic [31:0] t3 [3] = '{32'h0, 32'h100, 32'h200};
  logic [31:0] t4 [6] = '{32'd0, 32'd10, 32'd25, 32'd45, 32'd55, 32'd70};
  logic        c4 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [31:0] p0, p1, p3;
    tick;
    tick;
    chk("rst_phase", o_phase, 128'd0);
    chk("rst_ready", o_cfg_ready, 1'b0);
    chk("rst_valid", o_phase_valid, 1'b0);
    i_rst = 1'b1;
    tick;
    chk("ready_after_rst", o_cfg_ready, 1'b1);

    // Basic step on ch0
    wr(2'd0, 2'd0, 32'h4000_0000);
    sync(4'b0001);
    i_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("t1_phase%0d", k), o_phase[31:0], t1[k]);
      chk($sformatf("t1_valid%0d", k), o_phase_valid, 1'b1);
      chk($sformatf("t1_wrap%0d", k), o_wrap[0], (k == 3));
    end

    // Offset on ch1 while ch0 keeps running
    wr(2'd1, 2'd0, 32'd1);
    wr(2'd1, 2'd1, 32'hFFFF_FFFF);
    sync(4'b0010);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("t2_phase%0d", k), o_phase[63:32], t2[k]);
      chk($sformatf("t2_wrap%0d", k), o_wrap[1], 1'b0);
    end

    // Shadow isolation on ch0, ch1 uninterrupted
    p0 = o_phase[31:0];
    wr(2'd0, 2'd0, 32'h100);
    chk("t3_unsynced_step", o_phase[31:0] - p0, 32'h4000_0000);
    p1 = o_phase[63:32];
    sync(4'b0001);
    chk("t3_ch1_sync_cycle", o_phase[63:32] - p1, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("t3_phase%0d", k), o_phase[31:0], t3[k]);
      chk($sformatf("t3_ch1_%0d", k), o_phase[63:32] - p1, 32'(k + 2));
    end

    // Chirp on ch2
    wr(2'd2, 2'd0, 32'd10);
    wr(2'd2, 2'd2, 32'd5);
    wr(2'd2, 2'd3, 32'd20);
    sync(4'b0100);
    for (int k = 0; k < 6; k++) begin
      tick;
      chk($sformatf("t4_phase%0d", k), o_phase[95:64], t4[k]);
      chk($sformatf("t4_cwrap%0d", k), o_chirp_wrap[2], c4[k]);
    end

    // Disabled: outputs hold, pulses and valid low
    i_en = 1'b0;
    tick;
    tick;
    chk("hold_ch2", o_phase[95:64], 32'd70);
    chk("hold_valid", o_phase_valid, 1'b0);
    chk("hold_pulses", {o_wrap, o_chirp_wrap}, 8'h00);
    i_en = 1'b1;

    // Sync/write collision on ch3
    wr(2'd3, 2'd0, 32'd3);
    sync(4'b1000);
    i_cfg_valid = 1'b1;
    i_cfg_ch    = 2'd3;
    i_cfg_addr  = 2'd0;
    i_cfg_data  = 32'd7;
    i_sync      = 1'b1;
    i_sync_mask = 4'b1000;
    #1;
    chk("t5_ready_in_sync", o_cfg_ready, 1'b0);
    tick;
    i_sync      = 1'b0;
    i_sync_mask = '0;
    #1;
    chk("t5_ready_after", o_cfg_ready, 1'b1);
    tick;
    i_cfg_valid = 1'b0;
    tick;
    p3 = o_phase[127:96];
    tick;
    chk("t5_old_step", o_phase[127:96] - p3, 32'd3);
    sync(4'b1000);
    tick;
    p3 = o_phase[127:96];
    tick;
    chk("t5_new_step", o_phase[127:96] - p3, 32'd7);

    // Reset mid-run
    i_rst = 1'b0;
    tick;
    chk("t6_rst_phase", o_phase, 128'd0);
    chk("t6_rst_ready", o_cfg_ready, 1'b0);
    chk("t6_rst_pulses", {o_wrap, o_chirp_wrap, o_phase_valid}, 9'd0);
    i_rst = 1'b1;
    tick;
    chk("t6_ready", o_cfg_ready, 1'b1);
    tick;
    tick;
    chk("t6_phase_zero", o_phase, 128'd0);
    chk("t6_valid", o_phase_valid, 1'b1);

    i_en = 1'b0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
